// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator arithmetic sequencer.
package calc_pkg;

    localparam int CALC_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } seq_state_t;

endpackage

// File: rtl/calc_restoring_div.sv
// Restoring divider, one quotient bit per enable, MSB first.
// quotient/remainder present the values after the pending step, so the caller samples them on its last enable.
module calc_restoring_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            remainder = shifted[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            remainder = trial[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (en) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/shift-add-mul/restoring-div sequencer with registered result and done pulse.
// Define CALC_DIV_EN to build the divider; otherwise op=11 reports an error like divide-by-zero.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// MUL   | one shift-add step per cycle, WIDTH cycles
// DIV   | one restoring-division step per cycle, WIDTH cycles
// DONE  | done=1 for one cycle, then back to IDLE
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand, hi, lo;
    logic [WIDTH:0]   mul_sum;

    // Product lives in {hi, lo}: lo starts as the multiplier and is shifted out LSB first.
    assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};

`ifdef CALC_DIV_EN
    logic             div_load;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign div_load = (state == IDLE) && start && (op == OP_DIV) && (operand_b != '0);

    calc_restoring_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (reset_n),
        .load      (div_load),
        .en        (state == DIV),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        cnt   <= '0;
                        case (op)
                            OP_ADD: begin
                                {err, result} <= {1'b0, operand_a} + {1'b0, operand_b};
                                remainder     <= '0;
                                done          <= 1'b1;
                                state         <= DONE;
                            end
                            OP_SUB: begin
                                result    <= operand_a - operand_b;
                                err       <= (operand_b > operand_a);
                                remainder <= '0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end
                            OP_MUL: begin
                                mcand <= operand_a;
                                hi    <= '0;
                                lo    <= operand_b;
                                state <= MUL;
                            end
                            default: begin
`ifdef CALC_DIV_EN
                                if (operand_b != '0) begin
                                    state <= DIV;
                                end else begin
                                    result    <= '0;
                                    remainder <= '0;
                                    err       <= 1'b1;
                                    done      <= 1'b1;
                                    state     <= DONE;
                                end
`else
                                result    <= '0;
                                remainder <= '0;
                                err       <= 1'b1;
                                done      <= 1'b1;
                                state     <= DONE;
`endif
                            end
                        endcase
                    end
                end
                MUL: begin
                    hi  <= mul_sum[WIDTH:1];
                    lo  <= {mul_sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result    <= {mul_sum[0], lo[WIDTH-1:1]};
                        err       <= |mul_sum[WIDTH:1];
                        remainder <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef CALC_DIV_EN
                DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result    <= div_quo;
                        remainder <= div_rem;
                        err       <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle arithmetic sequencer between `control_unit` and the result path of the calculator. It accepts one operation at a time: operator code plus the two operands. Add and subtract finish in one cycle. Multiply runs as iterative shift-add and divide as iterative restoring division, so no wide combinational multiplier or divider sits in the design. It returns a registered result with a one-cycle `done` pulse and an error flag for the display path.

## Interface
- `WIDTH`, 32, operand/result width in bits (unsigned)
- `clk`  in  1  100 MHz system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only when `ready`=1
- `op`  in  2  00 add, 01 sub, 10 mul, 11 div
- `operand_a`  in  WIDTH  first operand, sampled on accepted `start`
- `operand_b`  in  WIDTH  second operand, sampled on accepted `start`
- `ready`  out  1  high in IDLE only
- `done`  out  1  one-cycle pulse, result/err valid
- `result`  out  WIDTH  sum / difference / product low bits / quotient
- `remainder`  out  WIDTH  division remainder, 0 for other ops
- `err`  out  1  carry, borrow, mul overflow, or divide-by-zero

## Operation
- Reset: state IDLE; `ready`=1, `done`=0, `result`=0, `remainder`=0, `err`=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE + `start`: latch operands and op; `ready` drops next cycle.
  - add/sub/div-by-zero → DONE.
  - mul → MUL.
  - div with b≠0 → DIV.
- add: `result`=(a+b) mod 2^WIDTH; `err`=carry out.
- sub: `result`=(a−b) mod 2^WIDTH; `err`=1 iff b>a.
- MUL: WIDTH iterations, one multiplier bit per cycle (LSB first), 2·WIDTH-bit accumulator. `result`=low WIDTH bits; `err`=1 iff high half ≠0.
- DIV: WIDTH iterations of restoring division, MSB first. `result`=quotient, `remainder`=remainder, `err`=0.
- Divide by zero: `result`=0, `remainder`=0, `err`=1, no iteration.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `result`/`remainder`/`err` hold until the next op's DONE. They do not change on accept.
- `start` while `ready`=0: ignored, no queuing.
- Changes to `op` or operands after accept: no effect.
- Iteration counter: log2(WIDTH)+1 bits, reset to 0 on each accept, no wrap beyond WIDTH.

## Timing
- Accept at edge N (start=1, ready=1).
- add/sub/div-by-0: `done`=1 in cycle N+1, `ready`=1 in N+2.
- mul/div: iterations in cycles N+1..N+WIDTH, `done` in N+WIDTH+1, `ready` in N+WIDTH+2.
- Back-to-back: `start` held high with `ready` → next accept in the cycle `ready` returns.
- Minimum period: 2 cycles for add/sub.
- `reset_n` low mid-operation: immediate return to reset values. No `done` for the aborted op.

## Configuration
- `CALC_DIV_EN` defined: divider and DIV state compiled in, behaviour as above.
- `CALC_DIV_EN` undefined: no divider logic. op=11 goes straight to DONE with `result`=0, `remainder`=0, `err`=1 (same timing as divide-by-zero).
- `remainder` port exists in both builds; tied to 0 when undefined.

## Structure
- Shared package `calc_pkg`:
  - op code constants `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_DIV`
  - typedef `calc_op_t`
  - state enum `seq_state_t`
  - default `CALC_WIDTH`=32
- Sub-module `calc_restoring_div`: one step per enable, exposes quotient/remainder. Instantiated only under `CALC_DIV_EN`.
- Multiplier iteration stays inline in `calc_op_sequencer`.

## Test plan
- Reset: hold `reset_n`=0 → `ready`=1, `done`=0, `result`=0, `err`=0. Release, add 1234+4321 → `result`=5555, `err`=0, `done` at N+1.
- Sub 5−9 → `result`=0xFFFFFFFC, `err`=1. Then add 0xFFFFFFFF+1 → `result`=0, `err`=1.
- Mul 12×34 → `result`=408, `err`=0, `done` at N+33. Mul 0x10000×0x10000 → `result`=0, `err`=1.
- Div 1000÷7 → `result`=142, `remainder`=6, `done` at N+33. Div 5÷0 → `err`=1, `result`=0, `done` at N+1. Without `CALC_DIV_EN`, div 1000÷7 → `err`=1 at N+1.
- `start` pulsed during a mul at N+5 → ignored, original result 408 delivered, exactly one `done`.
- `reset_n` asserted at N+10 of a div → outputs zero immediately, no `done`. Fresh add 2+3 afterwards → 5.
